// File: rtl/adc_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package adc_nibble_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int unsigned NIB_CNT_8  = 2;
  localparam int unsigned NIB_CNT_16 = 4;

  // Index of the last nibble to process for the selected width.
  function automatic logic [1:0] last_nib(input logic w16);
    return w16 ? 2'(NIB_CNT_16 - 1) : 2'(NIB_CNT_8 - 1);
  endfunction

endpackage

// File: rtl/adc_nibble_seq_if.sv
// Request/result bundle between a requester and the nibble sequencer.
interface adc_nibble_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        sub;
  logic        dec;
  logic        w16;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        co;
  logic        v;
  logic        z;
  logic        n;

  modport master (
    output start, a, b, ci, sub, dec, w16,
    input  busy, done, result, co, v, z, n
  );

  modport slave (
    input  start, a, b, ci, sub, dec, w16,
    output busy, done, result, co, v, z, n
  );
endinterface

// File: rtl/adc_nibble_seq_adder4.sv
// 4-bit ripple-carry adder shared by every nibble of an operation.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

// File: rtl/adc_nibble_seq.sv
// Nibble-serial binary/BCD add/subtract sequencer, 8- or 16-bit.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// RUN   | one nibble per cycle through adder4, LSB nibble first
// FIN   | results valid, done high for this single cycle
module adc_nibble_seq
  import adc_nibble_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  adc_nibble_seq_if.slave  bus
);
  state_t      state, state_nx;
  logic [15:0] a_sh, b_sh, res_sh;
  logic [7:0]  a_hi;
  logic        ci_r, sub_r, dec_r, w16_r;
  logic [1:0]  cnt;
  logic        carry_r;

  logic [3:0]  b_nib, sum_raw, nib_out;
  logic        add_co, nib_co, cin, last;
  logic [15:0] res_full, res_fin;
  logic        fin_z, fin_n, fin_v;

  logic [15:0] result_r;
  logic        co_r, v_r, z_r, n_r;

  assign b_nib = b_sh[3:0] ^ {4{sub_r}};
  assign cin   = (cnt == 2'd0) ? ci_r : carry_r;
  assign last  = (cnt == last_nib(w16_r));

  adder4 u_add (
    .a  (a_sh[3:0]),
    .b  (b_nib),
    .ci (cin),
    .s  (sum_raw),
    .co (add_co)
  );

  // Decimal correction of the raw nibble; binary mode passes through.
  always_comb begin
    nib_out = sum_raw;
    nib_co  = add_co;
    if (dec_r) begin
      if (!sub_r) begin
        if (sum_raw > 4'd9 || add_co) begin
          nib_out = sum_raw + 4'd6;
          nib_co  = 1'b1;
        end
      end else if (!add_co) begin
        nib_out = sum_raw + 4'hA;
      end
    end
  end

  // Final result assembly; in 8-bit mode the upper byte is A's upper byte.
  always_comb begin
    res_full = {nib_out, res_sh[15:4]};
    res_fin  = w16_r ? res_full : {a_hi, res_full[15:8]};
    fin_z    = w16_r ? (res_fin == 16'h0000) : (res_fin[7:0] == 8'h00);
    fin_n    = w16_r ? res_fin[15] : res_fin[7];
    // Overflow uses the uncorrected sum even in BCD mode.
    fin_v    = (a_sh[3] == b_nib[3]) && (sum_raw[3] != a_sh[3]);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.start) state_nx = ST_RUN;
      ST_RUN:  if (last)      state_nx = ST_FIN;
      ST_FIN:                 state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // Operand capture, nibble shifting and result/flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      a_hi     <= '0;
      ci_r     <= 1'b0;
      sub_r    <= 1'b0;
      dec_r    <= 1'b0;
      w16_r    <= 1'b0;
      cnt      <= '0;
      carry_r  <= 1'b0;
      result_r <= '0;
      co_r     <= 1'b0;
      v_r      <= 1'b0;
      z_r      <= 1'b0;
      n_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            a_hi    <= bus.a[15:8];
            ci_r    <= bus.ci;
            sub_r   <= bus.sub;
            dec_r   <= bus.dec;
            w16_r   <= bus.w16;
            cnt     <= '0;
            carry_r <= 1'b0;
          end
        end
        ST_RUN: begin
          a_sh    <= {4'h0, a_sh[15:4]};
          b_sh    <= {4'h0, b_sh[15:4]};
          res_sh  <= res_full;
          carry_r <= nib_co;
          cnt     <= cnt + 2'd1;
          if (last) begin
            result_r <= res_fin;
            co_r     <= nib_co;
            v_r      <= fin_v;
            z_r      <= fin_z;
            n_r      <= fin_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == ST_RUN);
  assign bus.done   = (state == ST_FIN);
  assign bus.result = result_r;
  assign bus.co     = co_r;
  assign bus.v      = v_r;
  assign bus.z      = z_r;
  assign bus.n      = n_r;
endmodule

// File: tb/tb_adc_nibble_seq.sv
// Directed bench for adc_nibble_seq with hand-computed expectations.
module tb_adc_nibble_seq;
  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  adc_nibble_seq_if bus ();

  adc_nibble_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one request; caller invokes it between edges. exp_f = {co,v,z,n}.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tci, input logic tsub, input logic tdec, input logic tw16,
                        input bit restart, input logic [15:0] exp_res, input logic [3:0] exp_f);
    int done_k = 0;
    int pulses = 0;
    int busy_n = 0;
    logic [15:0] res_at_done = 16'hxxxx;
    logic [3:0]  f_at_done   = 4'hx;
    bus.a = ta; bus.b = tb; bus.ci = tci; bus.sub = tsub; bus.dec = tdec; bus.w16 = tw16;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (restart) begin
      bus.a = 16'h5555; bus.b = 16'h5555; bus.sub = ~tsub;
    end else begin
      bus.start = 1'b0;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        pulses++;
        if (done_k == 0) begin
          done_k      = k;
          res_at_done = bus.result;
          f_at_done   = {bus.co, bus.v, bus.z, bus.n};
        end
      end
    end
    check({tag, " latency"}, done_k, tw16 ? 5 : 3);
    check({tag, " busy_cycles"}, busy_n, tw16 ? 4 : 2);
    check({tag, " done_pulses"}, pulses, 1);
    check({tag, " result"}, res_at_done, exp_res);
    check({tag, " flags"}, f_at_done, exp_f);
    check({tag, " result_held"}, bus.result, exp_res);
    check({tag, " flags_held"}, {bus.co, bus.v, bus.z, bus.n}, exp_f);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    bus.ci = 1'b0; bus.sub = 1'b0; bus.dec = 1'b0; bus.w16 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset result", bus.result, 16'h0000);
    check("reset flags", {bus.co, bus.v, bus.z, bus.n}, 4'b0000);
    rst = 1'b0;

    //                    a        b        ci    sub   dec   w16  rst?  result    {co,v,z,n}
    run_op("bin16_add",  16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 16'h1300, 4'b0000);
    run_op("bcd8_add",   16'h0099, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 4'b1010);
    run_op("bcd16_sub",  16'h1000, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b1, 0, 16'h0999, 4'b1000);
    run_op("bin8_ovf",   16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0080, 4'b0101);
    run_op("bin16_sub",  16'h5000, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 0, 16'h3DCC, 4'b1000);
    run_op("bin16_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 4'b1010);
    run_op("bin8_upper", 16'hAB10, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'hAB30, 4'b0000);
    run_op("bcd16_add",  16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b1, 0, 16'h6912, 4'b0000);
    run_op("bcd8_bad",   16'h00AF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h0015, 4'b1000);
    run_op("bcd8_borrow",16'h0010, 16'h0020, 1'b1, 1'b1, 1'b1, 1'b0, 0, 16'h0090, 4'b0001);
    run_op("restart16",  16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 1, 16'h0300, 4'b0000);
    run_op("bin8_ovf2",  16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0080, 4'b0101);

    // Reset in the middle of a 16-bit operation.
    bus.a = 16'h12FF; bus.b = 16'h0001; bus.ci = 1'b0; bus.sub = 1'b0;
    bus.dec = 1'b0; bus.w16 = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", bus.busy, 1'b0);
    check("midrst done", bus.done, 1'b0);
    check("midrst result", bus.result, 16'h0000);
    check("midrst flags", {bus.co, bus.v, bus.z, bus.n}, 4'b0000);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("midrst no_done", pulses, 0);
    rst = 1'b0;
    run_op("after_rst",  16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 16'h1300, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/adc_nibble_seq.md
ADC_NIBBLE_SEQ -- requirements
Module: adc_nibble_seq

Interface
REQ-001 SHALL have no parameters.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 START  in  1  one-cycle request; sampled only in IDLE.
REQ-005 A  in  16  first operand; captured on accepted START.
REQ-006 B  in  16  second operand; captured on accepted START.
REQ-007 CI  in  1  carry in (borrow-not for subtract); captured on START.
REQ-008 SUB  in  1  1 = subtract (A + ~B + CI); captured on START.
REQ-009 DEC  in  1  1 = BCD mode; captured on START.
REQ-010 W16  in  1  1 = 16-bit (4 nibbles), 0 = 8-bit (2 nibbles, upper result byte = A[15:8]); captured on START.
REQ-011 BUSY  out  1  high while RUN.
REQ-012 DONE  out  1  one-cycle pulse when results valid.
REQ-013 RESULT  out  16  sum/difference, held until next accepted START.
REQ-014 CO, V, Z, N  out  1 each  carry, overflow, zero, negative of final result, held like RESULT.

Function
REQ-015 States: IDLE, RUN, FIN; IDLE->RUN on START, RUN->FIN after last nibble, FIN->IDLE unconditionally.
REQ-016 START while RUN or FIN SHALL be ignored; operands not recaptured.
REQ-017 RUN SHALL process exactly one nibble per cycle, LSB nibble first, through a single shared 4-bit ripple adder.
REQ-018 Adder inputs per cycle: A nibble, B nibble (inverted when SUB), carry = CI on nibble 0, else registered carry of the previous nibble.
REQ-019 BCD add correction: if raw nibble > 9 or adder carry, add 6 (mod 16) and force nibble carry = 1.
REQ-020 BCD subtract correction: if adder carry = 0, add 0xA (mod 16); nibble carry = adder carry.
REQ-021 Binary mode: nibble carry = adder carry, no correction.
REQ-022 Latency: START at cycle t -> DONE at t+3 (8-bit) or t+5 (16-bit); BUSY high for 2 or 4 cycles.
REQ-023 CO = carry of last processed nibble.
REQ-024 V = (A_msb == B'_msb) && (uncorrected S_msb != A_msb) on the top nibble, B' = inverted B when SUB; computed identically in BCD mode.
REQ-025 Z = active-width result == 0; N = active-width result MSB (bit 7 or 15).
REQ-026 RESULT, CO, V, Z, N SHALL update only at the RUN->FIN transition; stable in IDLE/FIN.
REQ-027 Invalid BCD digits (A–F) SHALL be processed by the same rules without error indication.

Reset
REQ-028 RST SHALL force IDLE immediately, regardless of edge, including mid-RUN.
REQ-029 Reset values: BUSY=0, DONE=0, RESULT=0, CO=0, V=0, Z=0, N=0, nibble counter=0, carry register=0.
REQ-030 The first rising edge after RST deassertion SHALL be able to accept START.

Structure
REQ-031 State encoding and nibble-count constants (2, 4) SHALL live in the shared core package.
REQ-032 The nibble adder SHALL be one instance of the existing 4-bit ripple adder sub-module (adder4); correction logic lives in this module.
REQ-033 Operand and result registers SHALL shift by nibble; no 16-bit adder inferred.

Verification
REQ-034 Binary 16-bit add: A=0x12FF, B=0x0001, CI=0 -> DONE at t+5, RESULT=0x1300, CO=0, V=0, Z=0, N=0.
REQ-035 BCD 8-bit add: A=0x0099, B=0x0001, CI=0, DEC=1 -> DONE at t+3, RESULT=0x0000, CO=1, Z=1.
REQ-036 BCD 16-bit sub: A=0x1000, B=0x0001, CI=1, SUB=1, DEC=1 -> RESULT=0x0999, CO=1.
REQ-037 Binary 8-bit overflow: A=0x007F, B=0x0001, CI=0 -> RESULT=0x0080, V=1, N=1, CO=0.
REQ-038 START again at t+1 of a 16-bit op -> ignored, first result unchanged, DONE pulses once.
REQ-039 RST asserted at t+2 of a 16-bit op -> BUSY=0, DONE never pulses, all outputs 0; new START after release completes normally.
